disparity_search_ctrl: RTL

DISPARITY_SEARCH_CTRL -- requirements
Module: disparity_search_ctrl

---
 rtl/disparity_search_ctrl_if.sv | 30 +++
 rtl/disparity_search_ctrl.sv | 138 +++++++++++++
 2 files changed

// File: rtl/disparity_search_ctrl_if.sv
// Handshake bundle between the disparity search controller and its environment
// (request, window issue, correlation return and result channels).
interface disparity_search_ctrl_if #(
   parameter int unsigned DISP_W = 6,
   parameter int unsigned CRL_W  = 21
);
   logic              i_start;
   logic [10:0]       i_col;
   logic              o_ready;
   logic              i_win_ready;
   logic              o_win_valid;
   logic [DISP_W-1:0] o_win_disp;
   logic              i_crl_valid;
   logic [CRL_W-1:0]  i_crl;
   logic              o_disp_valid;
   logic              i_disp_ready;
   logic [DISP_W-1:0] o_disp;
   logic [CRL_W-1:0]  o_min_crl;
   logic              o_err;

   modport slave (
      input  i_start, i_col, i_win_ready, i_crl_valid, i_crl, i_disp_ready,
      output o_ready, o_win_valid, o_win_disp, o_disp_valid, o_disp, o_min_crl, o_err
   );

   modport master (
      output i_start, i_col, i_win_ready, i_crl_valid, i_crl, i_disp_ready,
      input  o_ready, o_win_valid, o_win_disp, o_disp_valid, o_disp, o_min_crl, o_err
   );
endinterface

// File: rtl/disparity_search_ctrl.sv
// Per-pixel disparity search: issues candidates 0..limit to the window datapath,
// tracks the minimum correlation as results return in order, and presents the winner.
module disparity_search_ctrl #(
   parameter int unsigned MAX_DISP = 32,
   parameter int unsigned DISP_W   = 6,
   parameter int unsigned CRL_W    = 21
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   disparity_search_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   // One extra bit so the issue counter can pass limit when limit is the max index.
   localparam int unsigned CntW   = DISP_W + 1;
   localparam logic [10:0] ColMax = 11'(MAX_DISP - 1);

   state_e            state_q, state_d;
   logic [DISP_W-1:0] limit_q, limit_d;
   logic [CntW-1:0]   issue_cnt_q, issue_cnt_d;
   logic [CntW-1:0]   rcv_cnt_q, rcv_cnt_d;
   logic [CRL_W-1:0]  min_q, min_d;
   logic [DISP_W-1:0] best_q, best_d;
   logic [DISP_W-1:0] disp_q, disp_d;
   logic [CRL_W-1:0]  min_crl_q, min_crl_d;
   logic              err_q, err_d;

   logic              searching;
   logic              issue;
   logic              rcv_ok;
   logic              rcv_last;
   logic              issue_last;

   always_comb begin
      state_d     = state_q;
      limit_d     = limit_q;
      issue_cnt_d = issue_cnt_q;
      rcv_cnt_d   = rcv_cnt_q;
      min_d       = min_q;
      best_d      = best_q;
      disp_d      = disp_q;
      min_crl_d   = min_crl_q;
      err_d       = err_q;

      searching  = (state_q == StIssue) || (state_q == StDrain);
      issue      = (state_q == StIssue) && bus.i_win_ready;
      issue_last = issue && (issue_cnt_q == {1'b0, limit_q});
      // A result is only legal while searching and with a candidate outstanding.
      rcv_ok     = searching && bus.i_crl_valid && (rcv_cnt_q < issue_cnt_q);
      rcv_last   = rcv_ok && (rcv_cnt_q == {1'b0, limit_q});

      if (bus.i_crl_valid && !rcv_ok) begin
         err_d = 1'b1;
      end

      if (issue) begin
         issue_cnt_d = issue_cnt_q + CntW'(1);
      end

      if (rcv_ok) begin
         rcv_cnt_d = rcv_cnt_q + CntW'(1);
         if (bus.i_crl < min_q) begin
            min_d  = bus.i_crl;
            best_d = rcv_cnt_q[DISP_W-1:0];
         end
      end

      if (rcv_last) begin
         disp_d    = best_d;
         min_crl_d = min_d;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.i_start) begin
               limit_d     = (bus.i_col > ColMax) ? ColMax[DISP_W-1:0] : bus.i_col[DISP_W-1:0];
               issue_cnt_d = '0;
               rcv_cnt_d   = '0;
               min_d       = '1;
               best_d      = '0;
               state_d     = StIssue;
            end
         end
         StIssue: begin
            if (rcv_last) begin
               state_d = StDone;
            end else if (issue_last) begin
               state_d = StDrain;
            end
         end
         StDrain: begin
            if (rcv_last) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (bus.i_disp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= StIdle;
         limit_q     <= '0;
         issue_cnt_q <= '0;
         rcv_cnt_q   <= '0;
         min_q       <= '1;
         best_q      <= '0;
         disp_q      <= '0;
         min_crl_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         limit_q     <= limit_d;
         issue_cnt_q <= issue_cnt_d;
         rcv_cnt_q   <= rcv_cnt_d;
         min_q       <= min_d;
         best_q      <= best_d;
         disp_q      <= disp_d;
         min_crl_q   <= min_crl_d;
         err_q       <= err_d;
      end
   end

   assign bus.o_ready      = (state_q == StIdle);
   assign bus.o_win_valid  = issue;
   assign bus.o_win_disp   = issue_cnt_q[DISP_W-1:0];
   assign bus.o_disp_valid = (state_q == StDone);
   assign bus.o_disp       = disp_q;
   assign bus.o_min_crl    = min_crl_q;
   assign bus.o_err        = err_q;

endmodule
